// File: rtl/rx_axis_frame_fifo_pkg.sv
// rtl/rx_axis_frame_fifo_pkg.sv - shared AXI-Stream beat layout for the MAC frame FIFOs
//
// Purpose : widths and field offsets of one buffered beat {tlast, tstrb, tdata},
//           shared by the RX and TX frame FIFOs.
// Ports   : none (package).
package rx_axis_frame_fifo_pkg;

    localparam int DATA_W   = 64;
    localparam int STRB_W   = 8;
    localparam int ENTRY_W  = DATA_W + STRB_W + 1;

    // Bit offsets of each field inside a stored entry.
    localparam int DATA_LSB = 0;
    localparam int STRB_LSB = DATA_W;
    localparam int LAST_BIT = DATA_W + STRB_W;

    typedef struct packed {
        logic              tlast;
        logic [STRB_W-1:0] tstrb;
        logic [DATA_W-1:0] tdata;
    } entry_t;

endpackage

// File: rtl/rx_axis_frame_fifo_if.sv
// rtl/rx_axis_frame_fifo_if.sv - AXI-Stream beat bundle with master/slave views
//
// Purpose : groups one AXI-Stream channel (64-bit data, 8-bit strobe).
// Ports   : tdata, tstrb, tvalid, tlast, tuser driven by the master;
//           tready driven by the slave.
interface rx_axis_frame_fifo_if;
    import rx_axis_frame_fifo_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic [STRB_W-1:0] tstrb;
    logic              tvalid;
    logic              tlast;
    logic              tuser;
    logic              tready;

    modport master (
        output tdata, tstrb, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tvalid, tlast, tuser,
        output tready
    );

endinterface

// File: rtl/rx_axis_frame_fifo_sdp_ram.sv
// rtl/rx_axis_frame_fifo_sdp_ram.sv - simple dual-port RAM with registered read
//
// Purpose : one write port, one read port whose data register only loads on
//           i_rd_en, so it can double as a holding output stage.
// Ports   : i_clk, i_rst_n (clears the read register only),
//           i_wr_en/i_wr_addr/i_wr_data, i_rd_en/i_rd_addr, o_rd_data.
module lmac_sdp_ram #(
    parameter int WIDTH  = 73,
    parameter int ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0] r_rd_data;

    // Storage array is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rx_axis_frame_fifo.sv
// rtl/rx_axis_frame_fifo.sv - store-and-forward RX frame FIFO with bad/overflow drop
//
// Purpose : buffers MAC RX frames, releases only complete good frames to the
//           host side, discards bad (tuser on tlast) and overflowing frames.
// Ports   : clk, rst_n (sync, active low)
//           s_axis       - slave stream from the MAC, never throttled
//           m_axis       - master stream to the host, full backpressure
//           frame_ok_cnt - committed good frames (saturating)
//           drop_bad_cnt - frames dropped for tuser (saturating)
//           drop_ovf_cnt - frames dropped for overflow (saturating)
module rx_axis_frame_fifo
    import rx_axis_frame_fifo_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rx_axis_frame_fifo_if.slave  s_axis,
    rx_axis_frame_fifo_if.master m_axis,
    output logic [31:0]          frame_ok_cnt,
    output logic [CNT_W-1:0]     drop_bad_cnt,
    output logic [CNT_W-1:0]     drop_ovf_cnt
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam logic [ADDR_W:0] FULL_DIFF = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0]  r_wr_ptr;
    logic [ADDR_W:0]  r_wr_commit;
    logic [ADDR_W:0]  r_rd_ptr;
    logic             r_drop;
    logic             r_s_tready;
    logic             r_m_tvalid;
    logic [31:0]      r_ok_cnt;
    logic [CNT_W-1:0] r_bad_cnt;
    logic [CNT_W-1:0] r_ovf_cnt;

    logic             w_acc;
    logic             w_full;
    logic             w_drop_beat;
    logic             w_wr_en;
    logic             w_eof;
    logic             w_rd_en;
    entry_t           w_wr_entry;
    entry_t           w_rd_entry;

    // ---------------- write side ----------------
    assign w_acc       = s_axis.tvalid & r_s_tready;
    assign w_full      = (r_wr_ptr - r_rd_ptr) == FULL_DIFF;
    // Beat is discarded if the frame is already doomed or there is no room.
    assign w_drop_beat = r_drop | w_full;
    assign w_wr_en     = w_acc & ~w_drop_beat;
    assign w_eof       = w_acc & s_axis.tlast;

    assign w_wr_entry.tlast = s_axis.tlast;
    assign w_wr_entry.tstrb = s_axis.tstrb;
    assign w_wr_entry.tdata = s_axis.tdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s_tready  <= 1'b0;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_drop      <= 1'b0;
            r_ok_cnt    <= '0;
            r_bad_cnt   <= '0;
            r_ovf_cnt   <= '0;
        end else begin
            r_s_tready <= 1'b1;

            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_acc && w_full && !s_axis.tlast) begin
                r_drop <= 1'b1;
            end

            // End-of-frame decisions override the per-beat updates above.
            if (w_eof) begin
                if (w_drop_beat) begin
                    r_wr_ptr <= r_wr_commit;
                    r_drop   <= 1'b0;
                    if (r_ovf_cnt != '1) begin
                        r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
                    end
                end else if (s_axis.tuser) begin
                    r_wr_ptr <= r_wr_commit;
                    if (r_bad_cnt != '1) begin
                        r_bad_cnt <= r_bad_cnt + CNT_W'(1);
                    end
                end else begin
                    r_wr_commit <= r_wr_ptr + 1'b1;
                    if (r_ok_cnt != '1) begin
                        r_ok_cnt <= r_ok_cnt + 32'd1;
                    end
                end
            end
        end
    end

    // ---------------- read side ----------------
    // The RAM read register is the output register: it loads a new committed
    // entry whenever it is empty or its current beat is being taken.
    assign w_rd_en = (r_rd_ptr != r_wr_commit) & (~r_m_tvalid | m_axis.tready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_m_tvalid <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_m_tvalid <= 1'b1;
            end else if (m_axis.tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    lmac_sdp_ram #(
        .WIDTH  (ENTRY_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_entry)
    );

    assign s_axis.tready = r_s_tready;

    assign m_axis.tdata  = w_rd_entry.tdata;
    assign m_axis.tstrb  = w_rd_entry.tstrb;
    assign m_axis.tlast  = w_rd_entry.tlast;
    assign m_axis.tvalid = r_m_tvalid;
    assign m_axis.tuser  = 1'b0;

    assign frame_ok_cnt  = r_ok_cnt;
    assign drop_bad_cnt  = r_bad_cnt;
    assign drop_ovf_cnt  = r_ovf_cnt;

endmodule

// File: tb/tb_rx_axis_frame_fifo.sv
// tb/tb_rx_axis_frame_fifo.sv - scoreboard bench for rx_axis_frame_fifo
module tb_rx_axis_frame_fifo;
    import rx_axis_frame_fifo_pkg::*;

    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rx_axis_frame_fifo_if s_if ();
    rx_axis_frame_fifo_if m_if ();

    logic [31:0]      ok_cnt;
    logic [CNT_W-1:0] bad_cnt;
    logic [CNT_W-1:0] ovf_cnt;

    rx_axis_frame_fifo #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .frame_ok_cnt (ok_cnt),
        .drop_bad_cnt (bad_cnt),
        .drop_ovf_cnt (ovf_cnt)
    );

    int     vectors = 0;
    int     errors  = 0;
    entry_t exp_q[$];
    int     exp_ok  = 0;
    int     exp_bad = 0;
    int     exp_ovf = 0;
    int     rdy_mode = 1;   // 0 hold low, 1 hold high, 2 toggle, 3 random

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Host-side ready driver.
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b0;
                1:       m_if.tready = 1'b1;
                2:       m_if.tready = ~m_if.tready;
                default: m_if.tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares every transfer with the scoreboard and checks stalls hold.
    initial begin
        logic        prev_stall;
        logic [73:0] held;
        entry_t      e;
        prev_stall = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold", {6'd0, m_if.tvalid, m_if.tlast, m_if.tstrb, m_if.tdata}, {6'd0, held});
                end
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 80'd1, 80'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", {16'd0, m_if.tdata}, {16'd0, e.tdata});
                        check("beat_strb", {72'd0, m_if.tstrb}, {72'd0, e.tstrb});
                        check("beat_last", {79'd0, m_if.tlast}, {79'd0, e.tlast});
                    end
                end
                prev_stall = m_if.tvalid && !m_if.tready;
                held       = {m_if.tvalid, m_if.tlast, m_if.tstrb, m_if.tdata};
            end
        end
    end

    // Idle cycle with junk on the sideband to show tvalid=0 beats are ignored.
    task automatic idle_cycle();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'($urandom);
        s_if.tuser  = 1'($urandom);
        s_if.tdata  = {$urandom, $urandom};
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic l, input logic u);
        s_if.tdata  = d;
        s_if.tstrb  = s;
        s_if.tlast  = l;
        s_if.tuser  = u;
        s_if.tvalid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Sends one frame and records its expected fate in the model.
    task automatic send_frame(input int len, input logic bad, input logic [7:0] last_strb,
                              input logic force_ovf, input int gap_pct);
        entry_t fr[$];
        entry_t e;
        for (int i = 0; i < len; i++) begin
            if (i != 0 && $urandom_range(0, 99) < gap_pct) idle_cycle();
            e.tdata = {$urandom, $urandom};
            e.tlast = (i == len - 1);
            e.tstrb = e.tlast ? last_strb : 8'hFF;
            fr.push_back(e);
            send_beat(e.tdata, e.tstrb, e.tlast, e.tlast ? bad : 1'($urandom));
        end
        s_if.tvalid = 1'b0;
        if (force_ovf || len > DEPTH) exp_ovf++;
        else if (bad)                 exp_bad++;
        else begin
            exp_ok++;
            foreach (fr[k]) exp_q.push_back(fr[k]);
        end
    endtask

    // Called right after a good frame's tlast was accepted into an idle FIFO.
    task automatic check_latency();
        check("lat_n_plus_1", {79'd0, m_if.tvalid}, 80'd0);
        @(posedge clk);
        #1;
        check("lat_n_plus_2", {79'd0, m_if.tvalid}, 80'd1);
    endtask

    task automatic wait_room(input int len);
        int t = 0;
        while (exp_q.size() + len > DEPTH && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 2000) check("room_timeout", 80'd1, 80'd0);
    endtask

    task automatic drain_check();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 3000) check("drain_timeout", 80'(exp_q.size()), 80'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("idle_tvalid", {79'd0, m_if.tvalid}, 80'd0);
        check("ok_cnt",  {48'd0, ok_cnt},  80'(exp_ok));
        check("bad_cnt", {64'd0, bad_cnt}, 80'(exp_bad));
        check("ovf_cnt", {64'd0, ovf_cnt}, 80'(exp_ovf));
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        s_if.tvalid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        exp_ok  = 0;
        exp_bad = 0;
        exp_ovf = 0;
        check("rst_s_tready", {79'd0, s_if.tready}, 80'd0);
        check("rst_m_tvalid", {79'd0, m_if.tvalid}, 80'd0);
        check("rst_m_out", {6'd0, m_if.tlast, m_if.tstrb, m_if.tdata}, 80'd0);
        check("rst_counters", {ok_cnt, bad_cnt, ovf_cnt}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("s_tready_after_rst", {79'd0, s_if.tready}, 80'd1);
    endtask

    initial begin
        int len;
        int n;
        int t;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tstrb  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        do_reset();

        // 1: good 3-beat frame, short last strobe, N+2 latency
        rdy_mode = 1;
        send_frame(3, 1'b0, 8'h0F, 1'b0, 0);
        check_latency();
        drain_check();

        // 2: bad frame then good frame
        send_frame(4, 1'b1, 8'hFF, 1'b0, 0);
        send_frame(2, 1'b0, 8'h3F, 1'b0, 0);
        drain_check();

        // 3: overflow of second frame while host is stalled
        rdy_mode = 0;
        repeat (2) idle_cycle();
        send_frame(10, 1'b0, 8'hFF, 1'b0, 0);
        send_frame(10, 1'b0, 8'hFF, 1'b1, 0);
        repeat (3) idle_cycle();
        check("ovf_held_valid", {79'd0, m_if.tvalid}, 80'd1);
        rdy_mode = 1;
        drain_check();

        // 4: oversize frame, then a single-beat frame
        send_frame(20, 1'b0, 8'hFF, 1'b0, 0);
        send_frame(1, 1'b0, 8'h01, 1'b0, 0);
        drain_check();

        // 5a: back-to-back frames under toggling ready
        rdy_mode = 2;
        for (int f = 0; f < 3; f++) send_frame(5, 1'b0, 8'h7F, 1'b0, 0);
        drain_check();

        // 5b: buffered frames stream out with no gaps once ready is held high
        rdy_mode = 0;
        repeat (2) idle_cycle();
        for (int f = 0; f < 3; f++) send_frame(5, 1'b0, 8'h1F, 1'b0, 0);
        repeat (3) idle_cycle();
        rdy_mode = 1;
        t = 0;
        while (!m_if.tready && t < 10) begin
            @(posedge clk);
            #1;
            t++;
        end
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (m_if.tvalid && m_if.tready) n++;
        end
        check("no_gap_beats", 80'(n), 80'd15);
        drain_check();

        // 6: reset mid-frame with an unread committed frame
        rdy_mode = 0;
        repeat (2) idle_cycle();
        send_frame(3, 1'b0, 8'hFF, 1'b0, 0);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
        do_reset();
        rdy_mode = 1;
        repeat (2) idle_cycle();
        check("post_rst_tvalid", {79'd0, m_if.tvalid}, 80'd0);
        send_frame(2, 1'b0, 8'hFF, 1'b0, 0);
        check_latency();
        drain_check();

        // random frames, random ready, random gaps
        rdy_mode = 3;
        for (int f = 0; f < 40; f++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 20) : $urandom_range(1, DEPTH);
            if (len <= DEPTH) wait_room(len);
            send_frame(len, ($urandom_range(0, 4) == 0), 8'($urandom_range(1, 255)), 1'b0, 20);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        rdy_mode = 1;
        drain_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rx_axis_frame_fifo.md
Name: rx_axis_frame_fifo

Overview:
Store-and-forward receive frame buffer that sits directly downstream of the MAC's RX AXI-Stream output (64-bit data, 8-bit strobe).
- Accepts every beat the MAC delivers and holds each frame until its last beat arrives.
- Forwards only frames with good FCS/status to the host-side AXI-Stream consumer, with full backpressure on that side.
- Discards bad frames (tuser=1 on tlast) and frames that overflow the buffer, and counts both.

Parameters:
ADDR_W, 9, log2 of buffer depth in 72+1-bit entries (default 512 beats = 4 KiB).
CNT_W, 16, width of the drop counters.

Ports:
clk  in  1  single clock for both the MAC side and the host side.
rst_n  in  1  synchronous, active-low reset.
s_axis_tdata  in  64  RX beat data from the MAC.
s_axis_tstrb  in  8  byte-valid strobe.
s_axis_tvalid  in  1  beat valid.
s_axis_tlast  in  1  last beat of frame.
s_axis_tuser  in  1  frame bad; sampled on the tlast beat only.
s_axis_tready  out  1  MAC-side ready; never used to throttle.
m_axis_tdata  out  64  host-side data.
m_axis_tstrb  out  8  host-side strobe.
m_axis_tvalid  out  1  host-side valid.
m_axis_tlast  out  1  host-side last.
m_axis_tready  in  1  host-side ready.
frame_ok_cnt  out  32  good frames committed; saturating.
drop_bad_cnt  out  CNT_W  frames dropped for tuser=1; saturating.
drop_ovf_cnt  out  CNT_W  frames dropped for overflow; saturating.

Behaviour:
- Reset values, held while rst_n=0 at a clk edge:
  - All pointers 0, drop flag 0, all counters 0.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tstrb=0.
- s_axis_tready is registered. It is 1 from the first edge after rst_n=1 and stays 1; overflow is handled by dropping, never by deasserting ready.
- Storage is a RAM of 2^ADDR_W entries {tlast, tstrb, tdata}. There are three pointers, each ADDR_W+1 bits and wrapping naturally:
  - wr_ptr: speculative write position.
  - wr_commit: end of the last committed frame.
  - rd_ptr: next entry to read.
- full = (wr_ptr - rd_ptr) == 2^ADDR_W. rd_ptr advances are visible to full one cycle later.
- Accepted beat (s_axis_tvalid & s_axis_tready):
  - Not dropping and not full: write at wr_ptr; wr_ptr++.
  - Not dropping and full: set the drop flag; the beat is discarded.
  - Dropping: discard the beat.
- On the tlast beat, evaluated after the rules above, in priority order:
  1. Drop flag set (including set by this beat): wr_ptr <= wr_commit, drop_ovf_cnt++, clear the drop flag.
  2. Else s_axis_tuser=1: wr_ptr <= wr_commit, drop_bad_cnt++.
  3. Else: wr_commit <= wr_ptr+1, frame_ok_cnt++.
- A frame longer than 2^ADDR_W beats always takes the overflow path. A single-beat frame is legal.
- Read side: one output register with a registered RAM read, i.e. one skid/prefetch stage.
  - m_axis_tvalid asserts when committed data exists (rd_ptr != wr_commit) and the output register is empty or being consumed.
  - Latency: tlast of a good frame accepted at cycle N → wr_commit updates at the end of N → first beat on m_axis with m_axis_tvalid=1 at cycle N+2, provided the output register was empty.
  - While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs hold stable.
  - With continuous m_axis_tready=1, throughput is 1 beat/cycle, including back-to-back frames.
  - Output never contains a partial or dropped frame; frames leave in arrival order.
- Simultaneous write and read in the same cycle is legal. Pointer wrap at 2^(ADDR_W+1) is seamless.
- Counters saturate at all-ones; no wrap.
- Reset mid-frame (either side): the partial input frame and all buffered frames are discarded; m_axis_tvalid=0 from the edge at which rst_n is sampled low.
- A beat with s_axis_tvalid=0 changes nothing, even if tlast or tuser toggle.

Decomposition:
- Shared package/include lmac_axis_defs: DATA_W=64, STRB_W=8, ENTRY_W=73, and field offsets of the {tlast, tstrb, tdata} entry. The TX-side frame FIFO reuses these.
- One sub-module, lmac_sdp_ram: simple dual-port RAM, one write port, one registered read port, parameterised by width and depth.
- Pointer, commit and drop logic and the output stage stay in rx_axis_frame_fifo.

Test Plan (bench uses ADDR_W=4, i.e. 16 entries):
1. Good frame of 3 beats, tstrb on the last beat = 8'h0F, tuser=0, m_axis_tready=1 → same 3 beats out, tlast on beat 3, first beat at N+2; frame_ok_cnt=1.
2. Bad frame: 4 beats with tuser=1 on tlast, followed by a good 2-beat frame → only the 2-beat frame emerges; drop_bad_cnt=1, frame_ok_cnt=1.
3. Overflow: m_axis_tready=0, send a 10-beat good frame then a 10-beat good frame → the first is held; the second reaches full at beat 7 and is dropped, so drop_ovf_cnt=1. Release ready → exactly 10 beats out, then m_axis_tvalid=0.
4. Oversize frame of 20 beats into an empty buffer → drop_ovf_cnt=1, nothing emitted. The next 1-beat good frame is emitted normally.
5. Backpressure: stream 3 back-to-back 5-beat frames while toggling m_axis_tready 1-0-1-0 → all 15 beats in order; outputs stable during every stall cycle; no gaps when ready is held at 1.
6. Reset asserted at beat 2 of a 4-beat frame while 1 committed frame is unread → after release m_axis_tvalid=0, counters=0; a subsequent good frame passes with the N+2 latency.
